// File: rtl/sram_req_arbiter_if.sv
`timescale 1ns/1ps
// SRAM-like request/response port: one request per addr_ok handshake, in-order data_ok.
// The master side issues requests; the slave side accepts them and returns responses.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
`timescale 1ns/1ps
// Shares one SRAM-like master port between inst and data requesters; data wins ties.
// Latency: request path 0 cycles (combinational grant), response path 0 cycles (steered by owner FIFO head).
// Backpressure: a presented request is locked until m.addr_ok; m.req drops while MAX_OUTST are outstanding.
module sram_req_arbiter #(
    parameter int MAX_OUTST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    sram_req_arbiter_if.slave             inst,
    sram_req_arbiter_if.slave             data,
    sram_req_arbiter_if.master            m,
    output logic [$clog2(MAX_OUTST):0]    outst_cnt,
    output logic                          proto_err
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } lock_st_t;

    lock_st_t       state;
    lock_st_t       state_nxt;
    logic           gnt_vld;
    logic           gnt_data;
    logic           gnt_req;
    logic           m_req_w;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           head_data;

    logic [MAX_OUTST-1:0] own_q;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        cnt;

    // Lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request left hanging at the edge pins the grant so the bridge never sees it change.
    always_comb begin
        state_nxt = state;
        if (m_req_w) begin
            if (m.addr_ok) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = gnt_data ? ST_LOCK_D : ST_LOCK_I;
            end
        end
    end

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_data = 1'b0;
        case (state)
            ST_LOCK_I: begin
                gnt_vld  = 1'b1;
                gnt_data = 1'b0;
            end
            ST_LOCK_D: begin
                gnt_vld  = 1'b1;
                gnt_data = 1'b1;
            end
            default: begin
                if (data.req) begin
                    gnt_vld  = 1'b1;
                    gnt_data = 1'b1;
                end else if (inst.req) begin
                    gnt_vld  = 1'b1;
                    gnt_data = 1'b0;
                end
            end
        endcase
    end

    assign full    = (cnt == CW'(MAX_OUTST));
    assign empty   = (cnt == '0);
    assign gnt_req = gnt_vld & (gnt_data ? data.req : inst.req);
    assign m_req_w = gnt_req & ~full & ~rst;

    assign m.req   = m_req_w;
    assign m.wr    = gnt_vld ? (gnt_data ? data.wr    : inst.wr)    : 1'b0;
    assign m.size  = gnt_vld ? (gnt_data ? data.size  : inst.size)  : 2'd0;
    assign m.wstrb = gnt_vld ? (gnt_data ? data.wstrb : inst.wstrb) : 4'd0;
    assign m.addr  = gnt_vld ? (gnt_data ? data.addr  : inst.addr)  : 32'd0;
    assign m.wdata = gnt_vld ? (gnt_data ? data.wdata : inst.wdata) : 32'd0;

    assign push = m_req_w & m.addr_ok;
    assign pop  = m.data_ok & ~empty & ~rst;

    assign inst.addr_ok = push & ~gnt_data;
    assign data.addr_ok = push & gnt_data;

    // Owner bit per outstanding transaction: 1 = data, 0 = inst
    assign head_data    = own_q[rd_ptr];
    assign inst.data_ok = pop & ~head_data;
    assign data.data_ok = pop & head_data;
    assign inst.rdata   = m.rdata;
    assign data.rdata   = m.rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                own_q[wr_ptr] <= gnt_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (m.data_ok && empty) begin
            proto_err <= 1'b1;
        end
    end

    assign outst_cnt = cnt;
endmodule

// File: tb/tb_sram_req_arbiter.sv
`timescale 1ns/1ps
// Bench for sram_req_arbiter: per-cycle vector table plus a response scoreboard.
module tb_sram_req_arbiter;
    localparam logic [31:0] IA = 32'h1fc0_0010;
    localparam logic [31:0] DA = 32'h8000_0ff4;
    localparam logic [31:0] IW = 32'h1111_2222;
    localparam logic [31:0] DW = 32'hcafe_f00d;
    localparam logic [6:0]  IC = {1'b0, 2'd2, 4'b1111};
    localparam logic [6:0]  DC = {1'b1, 2'd1, 4'b1100};

    typedef struct {
        bit rst, ireq, dreq, aok, dok;
        bit e_mreq, e_iaok, e_daok;
        int e_gnt;
        int e_cnt;
        bit e_perr;
    } vec_t;

    typedef struct {
        bit          owner_d;
        logic [31:0] rdata;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] outst_cnt;
    logic proto_err;

    sram_req_arbiter_if inst_if ();
    sram_req_arbiter_if data_if ();
    sram_req_arbiter_if m_if ();

    sram_req_arbiter #(.MAX_OUTST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst_if.slave),
        .data      (data_if.slave),
        .m         (m_if.master),
        .outst_cnt (outst_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_push = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit ir, input bit dr, input bit aok, input bit dok,
                                input bit emreq, input bit eia, input bit eda, input int gnt,
                                input int cnt, input bit perr);
        vec_t v;
        v.rst = r; v.ireq = ir; v.dreq = dr; v.aok = aok; v.dok = dok;
        v.e_mreq = emreq; v.e_iaok = eia; v.e_daok = eda;
        v.e_gnt = gnt; v.e_cnt = cnt; v.e_perr = perr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        sb_t         e;
        bit          have;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [6:0]  e_ctl;
        @(negedge clk);
        rst             = v.rst;
        inst_if.req     = v.ireq;
        data_if.req     = v.dreq;
        m_if.addr_ok    = v.aok;
        m_if.data_ok    = v.dok;
        have            = 1'b0;
        m_if.rdata      = 32'hdead_beef;
        e               = '{owner_d: 1'b0, rdata: 32'h0};
        if (v.dok && !v.rst && sb.size() > 0) begin
            e          = sb.pop_front();
            have       = 1'b1;
            m_if.rdata = e.rdata;
        end
        #2;
        e_addr  = (v.e_gnt == 1) ? IA : (v.e_gnt == 2) ? DA : 32'h0;
        e_wdata = (v.e_gnt == 1) ? IW : (v.e_gnt == 2) ? DW : 32'h0;
        e_ctl   = (v.e_gnt == 1) ? IC : (v.e_gnt == 2) ? DC : 7'h0;
        chk({tag, ".m_req"},   32'(m_if.req),        32'(v.e_mreq));
        chk({tag, ".i_aok"},   32'(inst_if.addr_ok), 32'(v.e_iaok));
        chk({tag, ".d_aok"},   32'(data_if.addr_ok), 32'(v.e_daok));
        chk({tag, ".m_addr"},  m_if.addr,            e_addr);
        chk({tag, ".m_wdata"}, m_if.wdata,           e_wdata);
        chk({tag, ".m_ctl"},   32'({m_if.wr, m_if.size, m_if.wstrb}), 32'(e_ctl));
        chk({tag, ".cnt"},     32'(outst_cnt),       32'(v.e_cnt));
        chk({tag, ".perr"},    32'(proto_err),       32'(v.e_perr));
        chk({tag, ".i_dok"},   32'(inst_if.data_ok), 32'(have && !e.owner_d));
        chk({tag, ".d_dok"},   32'(data_if.data_ok), 32'(have && e.owner_d));
        if (have) begin
            chk({tag, ".rdata"}, e.owner_d ? data_if.rdata : inst_if.rdata, e.rdata);
        end
        if (v.e_iaok || v.e_daok) begin
            sb.push_back('{owner_d: v.e_daok, rdata: 32'h0280_0000 + 32'(n_push)});
            n_push++;
        end
        if (v.rst) sb.delete();
    endtask

    initial begin
        inst_if.req = 1'b0; inst_if.wr = IC[6]; inst_if.size = IC[5:4]; inst_if.wstrb = IC[3:0];
        inst_if.addr = IA;  inst_if.wdata = IW;
        data_if.req = 1'b0; data_if.wr = DC[6]; data_if.size = DC[5:4]; data_if.wstrb = DC[3:0];
        data_if.addr = DA;  data_if.wdata = DW;
        m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0; m_if.rdata = 32'h0;

        //            rst ir dr ak dk  mreq ia da gnt cnt perr
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // single inst transaction, response two cycles later
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // simultaneous requests: data first, then inst
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // stalled inst request stays locked while data arrives
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // fill to MAX_OUTST, then pop/push at the full boundary
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 2, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 2, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 2, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 2, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 2, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, 2, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, 2, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // stray response with nothing outstanding
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // reset with 3 outstanding and an inst request locked on the port
        apply(mk(0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0), "h0");
        apply(mk(0, 0, 1, 1, 0, 1, 0, 1, 2, 1, 0), "h1");
        apply(mk(0, 1, 0, 1, 0, 1, 1, 0, 1, 2, 0), "h2");
        apply(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 3, 0), "h3");
        apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0), "h4");
        apply(mk(0, 1, 1, 0, 0, 1, 0, 0, 2, 0, 0), "h5");
        apply(mk(0, 1, 1, 1, 0, 1, 0, 1, 2, 0, 0), "h6");
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "h7");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "h8");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
